dmem_responder: RTL and testbench

//  Responder (memory side) of the CPU data-memory port. Accepts one load/store request at a time

---
 rtl/dmem_responder_pkg.sv | 36 +++
 rtl/dmem_responder_if.sv | 40 ++++
 rtl/dmem_responder_array.sv | 55 +++++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and helpers for the CPU data-memory responder.
//   WORD_W       : data word width (32)
//   BE_W         : byte-enable width (4)
//   dmem_state_t : responder FSM states
//   be_merge()   : byte-lane merge of a store into an existing word
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    // Replace only the byte lanes selected by be; other lanes keep old_w.
    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response channels of the CPU data-memory port.
//   master : CPU side (drives req_*, rsp_ready)
//   slave  : memory side (drives req_ready, rsp_*)
// Signals:
//   req_valid/req_ready   request handshake
//   req_write             1=store, 0=load
//   req_addr [31:0]       byte address
//   req_wdata[31:0]       store data
//   req_be   [3:0]        store byte enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata[31:0]       load data (0 for stores / errors)
//   rsp_err               misaligned access flag
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    import mips_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH_WORDS x 32-bit data storage with a byte-enabled synchronous write port
// and a synchronous read port. Contents start as Mem[i]=i (INIT_PATTERN=1) or
// all zero (INIT_PATTERN=0); reset does not touch the storage.
// Ports:
//   CLK      in   clock
//   i_en     in   read strobe: o_rdata samples word i_idx (pre-write value)
//   i_we     in   write strobe: lanes selected by i_be take i_wdata
//   i_idx    in   word index
//   i_wdata  in   write data
//   i_be     in   byte enables
//   o_rdata  out  registered read data, held between read strobes
// -----------------------------------------------------------------------------
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int INIT_PATTERN = 1,
    parameter int AW           = $clog2(DEPTH_WORDS)
) (
    input  logic              CLK,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] w_words [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    // One register per word so each can carry its own power-up value.
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [WORD_W-1:0] r_word = (INIT_PATTERN != 0) ? WORD_W'(g) : '0;

        always_ff @(posedge CLK) begin
            if (i_we && (i_idx == AW'(g))) begin
                r_word <= be_merge(r_word, i_wdata, i_be);
            end
        end

        assign w_words[g] = r_word;
    end

    always_ff @(posedge CLK) begin
        if (i_en) begin
            r_rdata <= w_words[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder of the CPU data-memory port. Accepts one load/store at
// a time, waits WAIT_STATES cycles, commits the access on the edge entering
// RESP and holds the response until the CPU takes it.
// Parameters: DEPTH_WORDS (words, address wraps), WAIT_STATES (0..15),
//             INIT_PATTERN (1: Mem[i]=i, 0: zero).
// Optional feature macro: DMEM_MISALIGN_ERR_EN -- when defined, an access with
//   req_addr[1:0]!=0 does not touch memory and responds rsp_err=1, rdata=0.
//   When undefined, req_addr[1:0] is ignored and rsp_err is always 0.
// Ports:
//   CLK   in   clock
//   rst   in   asynchronous active-high reset (memory contents kept)
//   bus   slave modport of dmem_responder_if (request/response channels)
// -----------------------------------------------------------------------------
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int WAIT_STATES  = 2,
    parameter int INIT_PATTERN = 1
) (
    input  logic               CLK,
    input  logic               rst,
    dmem_responder_if.slave    bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t       r_state;
    dmem_state_t       w_state_nxt;
    logic [3:0]        r_cnt;

    // Captured request (data path, no reset)
    logic              r_write;
    logic              r_mis;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    // Response control
    logic              r_rsp_load;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_commit;
    logic              w_mis_in;
    logic              w_c_write;
    logic              w_c_mis;
    logic [AW-1:0]     w_c_idx;
    logic [WORD_W-1:0] w_c_wdata;
    logic [BE_W-1:0]   w_c_be;
    logic [WORD_W-1:0] w_rd_data;
    logic              w_unused_addr;

    assign bus.req_ready = (r_state == DMEM_IDLE) && !rst;
    assign w_accept      = bus.req_valid && bus.req_ready;

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_mis_in = (bus.req_addr[1:0] != 2'b00);
`else
    assign w_mis_in = 1'b0;
`endif

    // Upper address bits wrap away; low two bits matter only for the error check.
    assign w_unused_addr = ^{bus.req_addr[WORD_W-1:AW+2], bus.req_addr[1:0]};

    // With zero wait states the commit happens on the accepting edge, so the
    // live request is used; otherwise the captured copy is.
    assign w_c_write = (r_state == DMEM_IDLE) ? bus.req_write           : r_write;
    assign w_c_mis   = (r_state == DMEM_IDLE) ? w_mis_in                : r_mis;
    assign w_c_idx   = (r_state == DMEM_IDLE) ? bus.req_addr[AW+1:2]    : r_idx;
    assign w_c_wdata = (r_state == DMEM_IDLE) ? bus.req_wdata           : r_wdata;
    assign w_c_be    = (r_state == DMEM_IDLE) ? bus.req_be              : r_be;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = DMEM_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DMEM_RESP;
                    w_commit    = 1'b1;
                end
            end
            DMEM_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = DMEM_IDLE;
                end
            end
            default: w_state_nxt = DMEM_IDLE;
        endcase
        // An in-flight store must never land while reset is asserted.
        if (rst) begin
            w_commit = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
        end else if ((r_state == DMEM_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_write <= bus.req_write;
            r_mis   <= w_mis_in;
            r_idx   <= bus.req_addr[AW+1:2];
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_rsp_load <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if (w_commit) begin
            r_rsp_load <= !w_c_write && !w_c_mis;
            r_rsp_err  <= w_c_mis;
        end
    end

    dmem_array #(
        .DEPTH_WORDS  (DEPTH_WORDS),
        .INIT_PATTERN (INIT_PATTERN),
        .AW           (AW)
    ) u_array (
        .CLK     (CLK),
        .i_en    (w_commit),
        .i_we    (w_commit && w_c_write && !w_c_mis),
        .i_idx   (w_c_idx),
        .i_wdata (w_c_wdata),
        .i_be    (w_c_be),
        .o_rdata (w_rd_data)
    );

    // Read data register only moves on commit, so gating it here keeps the
    // response stable through RESP and zero for stores, errors and reset.
    assign bus.rsp_valid = (r_state == DMEM_RESP);
    assign bus.rsp_rdata = r_rsp_load ? w_rd_data : '0;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders: u_a with WAIT_STATES=2 and u_b with WAIT_STATES=0, both
// INIT_PATTERN=1, DEPTH 256. Directed scenarios followed by random traffic,
// checked against a word-array reference model of the memory.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int WS_A = 2;

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    dmem_responder_if A ();
    dmem_responder_if B ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_A), .INIT_PATTERN(1)) u_a (
        .CLK (CLK),
        .rst (rst),
        .bus (A)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .INIT_PATTERN(1)) u_b (
        .CLK (CLK),
        .rst (rst),
        .bus (B)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m0 [256];
    logic [31:0] m1 [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input int which, input int idx);
        return (which == 0) ? m0[idx] : m1[idx];
    endfunction

    task automatic model_wr(input int which, input int idx, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = model_rd(which, idx);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        if (which == 0) m0[idx] = w;
        else            m1[idx] = w;
    endtask

    task automatic drive_req(input int which, input logic v, input logic w,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (which == 0) begin
            A.req_valid = v; A.req_write = w; A.req_addr = a; A.req_wdata = d; A.req_be = be;
        end else begin
            B.req_valid = v; B.req_write = w; B.req_addr = a; B.req_wdata = d; B.req_be = be;
        end
    endtask

    task automatic set_rr(input int which, input logic r);
        if (which == 0) A.rsp_ready = r;
        else            B.rsp_ready = r;
    endtask

    function automatic logic get_rdy(input int which);
        return (which == 0) ? A.req_ready : B.req_ready;
    endfunction

    function automatic logic get_vld(input int which);
        return (which == 0) ? A.rsp_valid : B.rsp_valid;
    endfunction

    function automatic logic [31:0] get_rd(input int which);
        return (which == 0) ? A.rsp_rdata : B.rsp_rdata;
    endfunction

    function automatic logic get_err(input int which);
        return (which == 0) ? A.rsp_err : B.rsp_err;
    endfunction

    // One complete transaction; called just after a rising edge (#1).
    task automatic txn(input int which, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input int hold, input logic queue_junk);
        logic [31:0] exp_d;
        logic        exp_e;
        logic [31:0] held;
        int          idx;
        int          n;
        idx   = int'(a[9:2]);
        exp_e = 1'b0;
        exp_d = 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
        if (a[1:0] != 2'b00) exp_e = 1'b1;
`endif
        if (!exp_e) begin
            if (w) model_wr(which, idx, d, be);
            else   exp_d = model_rd(which, idx);
        end

        set_rr(which, 1'b0);
        drive_req(which, 1'b1, w, a, d, be);
        n = 0;
        while (!get_rdy(which) && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("accept_wait", 32'(n < 20), 32'd1);
        @(posedge CLK); #1;
        drive_req(which, 1'b0, 1'b0, $urandom, $urandom, 4'h0);

        n = 1;
        while (!get_vld(which) && n < 30) begin
            @(posedge CLK); #1;
            n++;
        end
        check("latency", 32'(n), (which == 0) ? 32'(WS_A + 1) : 32'd1);
        check("rdata", get_rd(which), exp_d);
        check("err", 32'(get_err(which)), 32'(exp_e));
        held = get_rd(which);

        for (int h = 0; h < hold; h++) begin
            if (queue_junk) drive_req(which, 1'b1, 1'b1, $urandom, $urandom, 4'hF);
            @(posedge CLK); #1;
            check("hold_vld", 32'(get_vld(which)), 32'd1);
            check("hold_rdata", get_rd(which), held);
            check("hold_rdy", 32'(get_rdy(which)), 32'd0);
        end

        set_rr(which, 1'b1);
        @(posedge CLK); #1;
        set_rr(which, 1'b0);
        drive_req(which, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        check("post_vld", 32'(get_vld(which)), 32'd0);
        check("post_rdy", 32'(get_rdy(which)), 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            m0[i] = 32'(i);
            m1[i] = 32'(i);
        end
        rst = 1'b1;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        set_rr(0, 1'b0);
        set_rr(1, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_vld", 32'(A.rsp_valid), 32'd0);
        check("rst_rdy", 32'(A.req_ready), 32'd0);
        check("rst_rdata", A.rsp_rdata, 32'd0);
        check("rst_err", 32'(A.rsp_err), 32'd0);
        check("rst_vld_b", 32'(B.rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 32'(A.req_ready), 32'd1);
        @(posedge CLK); #1;

        // Load of the initial pattern: word 4 at 0x10
        txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);
        check("init_word4", m0[4], 32'h4);

        // Full store then load, both wait-state configurations
        txn(0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1, 1'b0);
        txn(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0);
        txn(1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        txn(1, 1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0);

        // Partial store and address wrap
        txn(0, 1'b1, 32'h24, 32'h12345678, 4'h3, 0, 1'b0);
        txn(0, 1'b0, 32'h24, 32'd0, 4'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h424, 32'd0, 4'h0, 0, 1'b0);
        check("word9_partial", m0[9], 32'h00005678);
        txn(0, 1'b1, 32'h28, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h28, 32'd0, 4'hF, 0, 1'b0);

        // Backpressure with a queued request that must not be taken
        txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 5, 1'b1);
        txn(1, 1'b0, 32'h44, 32'd0, 4'h0, 3, 1'b1);

        // Reset during the wait phase of a store
        drive_req(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        n = 0;
        while (!A.req_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        @(posedge CLK); #1;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(posedge CLK); #1;
        check("wait_rdy", 32'(A.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_vld", 32'(A.rsp_valid), 32'd0);
        check("midrst_rdy", 32'(A.req_ready), 32'd0);
        @(posedge CLK); #1;
        rst = 1'b0;
        @(posedge CLK); #1;
        txn(0, 1'b0, 32'h30, 32'd0, 4'h0, 0, 1'b0);
        check("word12_kept", m0[12], 32'h0000000C);

        // Misaligned store into word 8, then aligned read back
        txn(0, 1'b1, 32'h22, 32'hA5A5A5A5, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0);
        txn(1, 1'b1, 32'h22, 32'h5A5A5A5A, 4'hF, 0, 1'b0);
        txn(1, 1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            int wh;
            wh = (t % 4 == 3) ? 1 : 0;
            txn(wh, 1'($urandom_range(0, 1)), $urandom, $urandom,
                4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
